// File: rtl/load_store_unit.sv
// MIPS-style load/store unit: one outstanding access, byte-lane formatting, timeout abort.
// Define LSU_ALIGN_CHECK_EN to trap misaligned halfword/word accesses.
module load_store_unit #(
  parameter int TIMEOUT_CYCLES = 16
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        start,
  input  logic [5:0]  opcode,
  input  logic [31:0] addr,
  input  logic [31:0] store_data,
  input  logic [4:0]  rt,
  output logic        busy,
  output logic        done,
  output logic        err,
  output logic        mem_req,
  output logic        mem_we,
  output logic [31:0] mem_addr,
  output logic [31:0] mem_wdata,
  output logic [3:0]  mem_be,
  input  logic        mem_ack,
  input  logic [31:0] mem_rdata,
  output logic        rf_we,
  output logic [4:0]  rf_waddr,
  output logic [31:0] rf_wdata
);

  localparam int CW = $clog2(TIMEOUT_CYCLES + 1);

  localparam logic [5:0] OP_LB  = 6'h20;
  localparam logic [5:0] OP_LH  = 6'h21;
  localparam logic [5:0] OP_LW  = 6'h23;
  localparam logic [5:0] OP_LBU = 6'h24;
  localparam logic [5:0] OP_LHU = 6'h25;
  localparam logic [5:0] OP_SB  = 6'h28;
  localparam logic [5:0] OP_SH  = 6'h29;
  localparam logic [5:0] OP_SW  = 6'h2B;

  typedef enum logic [2:0] {
    IDLE, ACCESS, FIN, WB, ERR
  } state_t;

  state_t          state;
  logic [5:0]      op_q;
  logic [1:0]      lane_q;
  logic [4:0]      rt_q;
  logic            st_q;
  logic [CW-1:0]   tcnt;

  logic            is_load;
  logic            is_store;
  logic            misalign;
  logic [31:0]     wdata_n;
  logic [3:0]      be_n;
  logic [7:0]      byte_sel;
  logic [15:0]     half_sel;
  logic [31:0]     load_val;

  always_comb begin
    is_load  = 1'b0;
    is_store = 1'b0;
    case (opcode)
      OP_LB, OP_LH, OP_LW,
      OP_LBU, OP_LHU:      is_load = 1'b1;
      OP_SB, OP_SH, OP_SW: is_store = 1'b1;
      default: ;
    endcase
  end

`ifdef LSU_ALIGN_CHECK_EN
  always_comb begin
    misalign = 1'b0;
    case (opcode)
      OP_LH, OP_LHU, OP_SH: misalign = addr[0];
      OP_LW, OP_SW:         misalign = (addr[1:0] != 2'b00);
      default: ;
    endcase
  end
`else
  assign misalign = 1'b0;
`endif

  // Stores are formatted at issue so mem_* can be registered directly.
  always_comb begin
    wdata_n = 32'h0;
    be_n    = 4'h0;
    case (opcode)
      OP_SB: begin
        wdata_n = {4{store_data[7:0]}};
        be_n    = 4'b0001 << addr[1:0];
      end
      OP_SH: begin
        wdata_n = {2{store_data[15:0]}};
        be_n    = 4'b0011 << {addr[1], 1'b0};
      end
      OP_SW: begin
        wdata_n = store_data;
        be_n    = 4'b1111;
      end
      default: ;
    endcase
  end

  assign byte_sel = mem_rdata[{lane_q, 3'b000} +: 8];
  assign half_sel = lane_q[1] ? mem_rdata[31:16] : mem_rdata[15:0];

  always_comb begin
    load_val = mem_rdata;
    case (op_q)
      OP_LB:  load_val = {{24{byte_sel[7]}}, byte_sel};
      OP_LBU: load_val = {24'h0, byte_sel};
      OP_LH:  load_val = {{16{half_sel[15]}}, half_sel};
      OP_LHU: load_val = {16'h0, half_sel};
      default: ;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= IDLE;
      op_q      <= 6'h0;
      lane_q    <= 2'b00;
      rt_q      <= 5'd0;
      st_q      <= 1'b0;
      tcnt      <= '0;
      busy      <= 1'b0;
      done      <= 1'b0;
      err       <= 1'b0;
      mem_req   <= 1'b0;
      mem_we    <= 1'b0;
      mem_addr  <= 32'h0;
      mem_wdata <= 32'h0;
      mem_be    <= 4'h0;
      rf_we     <= 1'b0;
      rf_waddr  <= 5'd0;
      rf_wdata  <= 32'h0;
    end else begin
      done  <= 1'b0;
      err   <= 1'b0;
      rf_we <= 1'b0;
      unique case (state)
        IDLE: begin
          if (start) begin
            op_q   <= opcode;
            lane_q <= addr[1:0];
            rt_q   <= rt;
            st_q   <= is_store;
            busy   <= 1'b1;
            if ((!is_load && !is_store) || misalign) begin
              state <= ERR;
              done  <= 1'b1;
              err   <= 1'b1;
            end else begin
              state     <= ACCESS;
              tcnt      <= '0;
              mem_req   <= 1'b1;
              mem_we    <= is_store;
              mem_addr  <= {addr[31:2], 2'b00};
              mem_wdata <= wdata_n;
              mem_be    <= be_n;
            end
          end
        end
        ACCESS: begin
          if (mem_ack) begin
            mem_req   <= 1'b0;
            mem_we    <= 1'b0;
            mem_wdata <= 32'h0;
            mem_be    <= 4'h0;
            done      <= 1'b1;
            if (st_q) begin
              state <= FIN;
            end else begin
              state    <= WB;
              rf_we    <= (rt_q != 5'd0);
              rf_waddr <= rt_q;
              rf_wdata <= load_val;
            end
          end else if (tcnt == CW'(TIMEOUT_CYCLES - 1)) begin
            mem_req   <= 1'b0;
            mem_we    <= 1'b0;
            mem_wdata <= 32'h0;
            mem_be    <= 4'h0;
            state     <= ERR;
            done      <= 1'b1;
            err       <= 1'b1;
          end else begin
            tcnt <= tcnt + 1'b1;
          end
        end
        FIN, WB, ERR: begin
          state <= IDLE;
          busy  <= 1'b0;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_load_store_unit.sv
// Directed self-checking bench for load_store_unit.
// Honours LSU_ALIGN_CHECK_EN for the misaligned-word case.
module tb_load_store_unit;

  localparam logic [5:0] OP_LB  = 6'h20;
  localparam logic [5:0] OP_LH  = 6'h21;
  localparam logic [5:0] OP_LW  = 6'h23;
  localparam logic [5:0] OP_LBU = 6'h24;
  localparam logic [5:0] OP_LHU = 6'h25;
  localparam logic [5:0] OP_SB  = 6'h28;
  localparam logic [5:0] OP_SH  = 6'h29;
  localparam logic [5:0] OP_SW  = 6'h2B;

  logic        clk = 1'b0;
  logic        rst;
  logic        start;
  logic [5:0]  opcode;
  logic [31:0] addr;
  logic [31:0] store_data;
  logic [4:0]  rt;
  logic        busy;
  logic        done;
  logic        err;
  logic        mem_req;
  logic        mem_we;
  logic [31:0] mem_addr;
  logic [31:0] mem_wdata;
  logic [3:0]  mem_be;
  logic        mem_ack;
  logic [31:0] mem_rdata;
  logic        rf_we;
  logic [4:0]  rf_waddr;
  logic [31:0] rf_wdata;

  int n_tests = 0;
  int n_fail  = 0;

  load_store_unit #(.TIMEOUT_CYCLES(16)) dut (
    .clk(clk), .rst(rst), .start(start), .opcode(opcode),
    .addr(addr), .store_data(store_data), .rt(rt),
    .busy(busy), .done(done), .err(err),
    .mem_req(mem_req), .mem_we(mem_we), .mem_addr(mem_addr),
    .mem_wdata(mem_wdata), .mem_be(mem_be),
    .mem_ack(mem_ack), .mem_rdata(mem_rdata),
    .rf_we(rf_we), .rf_waddr(rf_waddr), .rf_wdata(rf_wdata)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got,
                       input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %08h expected %08h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic begin_op(input logic [5:0] op, input logic [31:0] a,
                          input logic [31:0] d, input logic [4:0] r);
    start      = 1'b1;
    opcode     = op;
    addr       = a;
    store_data = d;
    rt         = r;
    tick();
    start      = 1'b0;
    opcode     = 6'h00;
    addr       = 32'hFFFF_FFFF;
    store_data = 32'h0;
    rt         = 5'd31;
  endtask

  task automatic ack_after(input int n, input logic [31:0] d);
    repeat (n) tick();
    mem_ack   = 1'b1;
    mem_rdata = d;
    tick();
    mem_ack   = 1'b0;
    mem_rdata = 32'h5A5A_5A5A;
  endtask

  task automatic load(input string tag, input logic [5:0] op,
                      input logic [31:0] a, input logic [4:0] r,
                      input logic [31:0] d, input logic [31:0] exp);
    begin_op(op, a, 32'h0, r);
    check({tag, "_we"}, {31'h0, mem_we}, 32'h0);
    check({tag, "_be"}, {28'h0, mem_be}, 32'h0);
    ack_after(0, d);
    check({tag, "_done"}, {31'h0, done}, 32'h1);
    check({tag, "_rfwe"}, {31'h0, rf_we}, {31'h0, r != 5'd0});
    if (r != 5'd0) begin
      check({tag, "_waddr"}, {27'h0, rf_waddr}, {27'h0, r});
      check({tag, "_wdata"}, rf_wdata, exp);
    end
    tick();
    check({tag, "_idle"}, {30'h0, busy, done}, 32'h0);
  endtask

  initial begin
    rst = 1'b1; start = 1'b0; opcode = 6'h0; addr = 32'h0;
    store_data = 32'h0; rt = 5'd0; mem_ack = 1'b0; mem_rdata = 32'h0;
    tick(); tick();
    rst = 1'b0;
    check("rst_ctl", {28'h0, busy, done, err, rf_we}, 32'h0);
    check("rst_mem", {30'h0, mem_req, mem_we}, 32'h0);
    check("rst_addr", mem_addr, 32'h0);
    check("rst_wdata", mem_wdata, 32'h0);
    check("rst_be", {28'h0, mem_be}, 32'h0);
    check("rst_rf", rf_wdata | {27'h0, rf_waddr}, 32'h0);

    mem_ack = 1'b1;
    tick();
    mem_ack = 1'b0;
    check("stray_ack", {30'h0, busy, done}, 32'h0);

    begin_op(OP_SB, 32'h13, 32'h0000_00A5, 5'd4);
    check("sb_req", {30'h0, mem_req, mem_we}, 32'h3);
    check("sb_addr", mem_addr, 32'h10);
    check("sb_be", {28'h0, mem_be}, 32'h8);
    check("sb_wdata", mem_wdata, 32'hA5A5_A5A5);
    check("sb_busy", {31'h0, busy}, 32'h1);
    tick();
    check("sb_hold", mem_addr, 32'h10);
    check("sb_hold_req", {31'h0, mem_req}, 32'h1);
    ack_after(0, 32'h0);
    check("sb_done", {31'h0, done}, 32'h1);
    check("sb_rfwe", {31'h0, rf_we}, 32'h0);
    check("sb_release", {27'h0, mem_req, mem_we, 3'b000}, 32'h0);
    check("sb_zero", mem_wdata | {28'h0, mem_be}, 32'h0);
    tick();
    check("sb_end", {30'h0, busy, done}, 32'h0);

    begin_op(OP_SH, 32'h12, 32'h1234_BEEF, 5'd0);
    check("sh_be", {28'h0, mem_be}, 32'hC);
    check("sh_wdata", mem_wdata, 32'hBEEF_BEEF);
    ack_after(0, 32'h0);
    check("sh_done", {31'h0, done}, 32'h1);
    tick();

`ifdef LSU_ALIGN_CHECK_EN
    begin_op(OP_SW, 32'h6, 32'h1122_3344, 5'd0);
    check("sw_mis_err", {30'h0, err, done}, 32'h3);
    check("sw_mis_req", {31'h0, mem_req}, 32'h0);
    tick();
    check("sw_mis_end", {29'h0, busy, err, mem_req}, 32'h0);
`else
    begin_op(OP_SW, 32'h6, 32'h1122_3344, 5'd0);
    check("sw_addr", mem_addr, 32'h4);
    check("sw_be", {28'h0, mem_be}, 32'hF);
    check("sw_wdata", mem_wdata, 32'h1122_3344);
    begin_op(OP_LB, 32'h40, 32'h0, 5'd2);
    check("busy_start", mem_addr, 32'h4);
    check("busy_start_we", {31'h0, mem_we}, 32'h1);
    ack_after(0, 32'h0);
    check("sw_done", {31'h0, done}, 32'h1);
    tick();
`endif

    load("lb",  OP_LB,  32'h22, 5'd5, 32'h00F0_0000, 32'hFFFF_FFF0);
    load("lbu", OP_LBU, 32'h22, 5'd5, 32'h00F0_0000, 32'h0000_00F0);
    load("lh0", OP_LH,  32'h2,  5'd0, 32'h8001_FFFF, 32'h0);
    load("lh",  OP_LH,  32'h2,  5'd7, 32'h8001_FFFF, 32'hFFFF_8001);
    load("lhu", OP_LHU, 32'h2,  5'd7, 32'h8001_FFFF, 32'h0000_8001);
    load("lw",  OP_LW,  32'h8,  5'd9, 32'hDEAD_BEEF, 32'hDEAD_BEEF);

    begin_op(6'h22, 32'h0, 32'h0, 5'd1);
    check("ill_err", {30'h0, err, done}, 32'h3);
    check("ill_req", {31'h0, mem_req}, 32'h0);
    tick();
    check("ill_end", {30'h0, busy, err}, 32'h0);

    begin_op(OP_LW, 32'h20, 32'h0, 5'd6);
    for (int i = 1; i <= 16; i++) begin
      check($sformatf("to_wait%0d", i), {30'h0, mem_req, err}, 32'h2);
      tick();
    end
    check("to_err", {30'h0, err, done}, 32'h3);
    check("to_req", {30'h0, mem_req, rf_we}, 32'h0);
    tick();
    check("to_end", {30'h0, busy, err}, 32'h0);

    begin_op(OP_LW, 32'h100, 32'h0, 5'd3);
    rst = 1'b1;
    tick();
    rst = 1'b0;
    check("rst_acc", {30'h0, mem_req, busy}, 32'h0);
    ack_after(0, 32'h1111_1111);
    check("rst_ack", {30'h0, done, rf_we}, 32'h0);
    tick();
    check("rst_quiet", {30'h0, done, rf_we}, 32'h0);
    load("post_rst", OP_LW, 32'h104, 5'd3, 32'hCAFE_F00D, 32'hCAFE_F00D);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
